// File: rtl/mux_stream_nto1.sv
// N-channel, W-bit valid/ready stream multiplexer with a registered output stage.
// Channel selection is either an external select or a fair round-robin rotation.
module mux_stream_nto1 #(
  parameter int  WIDTH    = 3,
  parameter int  CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // One spare bit so that ptr + offset cannot overflow before the modulo fold.
  localparam int                EXT_W   = SEL_W + 1;
  localparam logic [EXT_W-1:0]  CH_EXT  = EXT_W'(CHANNELS);
  localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]    grant_s;
  logic                grant_vld_s;
  logic [EXT_W-1:0]    cand_s;
  logic                load_en_s;
  logic                xfer_s;
  logic [CHANNELS-1:0] in_ready_s;

  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_chan_q, out_chan_d;
  logic                out_valid_q, out_valid_d;

  // Grant selection: external select in fixed mode, first valid channel from ptr in RR mode.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    cand_s      = '0;
    if (mode == 1'b0) begin
      if ({1'b0, sel} < CH_EXT) begin
        grant_s     = sel;
        grant_vld_s = 1'b1;
      end else begin
        grant_s     = '0;
        grant_vld_s = 1'b0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        cand_s = {1'b0, ptr_q} + EXT_W'(k);
        if (cand_s >= CH_EXT) begin
          cand_s = cand_s - CH_EXT;
        end else begin
          cand_s = cand_s;
        end
        if (!grant_vld_s && in_valid[cand_s[SEL_W-1:0]]) begin
          grant_s     = cand_s[SEL_W-1:0];
          grant_vld_s = 1'b1;
        end else begin
          grant_s     = grant_s;
          grant_vld_s = grant_vld_s;
        end
      end
    end
  end

  assign load_en_s = !out_valid_q || out_ready;
  assign xfer_s    = grant_vld_s && in_valid[grant_s] && load_en_s;

  // One-hot ready toward the granted producer, forced low while in reset.
  always_comb begin
    in_ready_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in_ready_s[c] = rst_n & grant_vld_s & load_en_s & (grant_s == SEL_W'(c));
    end
  end

  assign in_ready = in_ready_s;

  // Output register and RR pointer next-state.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en_s) begin
      if (xfer_s) begin
        out_data_d  = in_data[int'(grant_s)*WIDTH +: WIDTH];
        out_chan_d  = grant_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
    if (xfer_s && mode) begin
      if (grant_s == LAST_CH) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_s + SEL_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Self-checking bench for mux_stream_nto1: directed scenarios on 4- and 3-channel
// instances plus a randomized run against a queue-free behavioural model.
module tb_mux_stream_nto1;
  localparam int W  = 3;
  localparam int C  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid, in_ready;
  logic           mode, out_valid, out_ready;
  logic [SW-1:0]  sel, out_chan;
  logic [W-1:0]   out_data;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3, in_ready3;
  logic           mode3, out_valid3, out_ready3;
  logic [1:0]     sel3, out_chan3;
  logic [W-1:0]   out_data3;

  mux_stream_nto1 #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready));

  mux_stream_nto1 #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3));

  int checks   = 0;
  int failures = 0;

  // Reference model state: held output word and the round-robin pointer.
  bit          mv;
  logic [W-1:0] md;
  int          mc;
  int          mp;

  function automatic int ref_grant(input bit m, input int s, input logic [C-1:0] v, input int p);
    if (!m) return (s < C) ? s : -1;
    for (int k = 0; k < C; k++) begin
      if (v[(p + k) % C]) return (p + k) % C;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data = {3'd0, 3'b101, 3'd0, 3'd0};
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 3'd0) begin failures++; $display("FAIL rst_data got=%b exp=000", out_data); end
    checks++; if (out_chan !== 2'd0) begin failures++; $display("FAIL rst_chan got=%0d exp=0", out_chan); end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", in_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL pass_ready got=%b exp=0100", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 3'b101 || out_chan !== 2'd2) begin
      failures++; $display("FAIL pass_out got=%b/%b/%0d exp=1/101/2", out_valid, out_data, out_chan); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_data = {3'd0, 3'b011, 3'd0, 3'd0};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 3'b101 || out_chan !== 2'd2) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%b/%0d exp=1/101/2", i, out_valid, out_data, out_chan); end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 3'b011 || out_chan !== 2'd2) begin
      failures++; $display("FAIL bp_next got=%b/%b/%0d exp=1/011/2", out_valid, out_data, out_chan); end
    in_valid = 4'b0000;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_nodup got=%b exp=0", out_valid); end
  endtask

  task automatic test_rr_fairness();
    int exp_a [6] = '{0, 1, 2, 3, 0, 1};
    int exp_b [4] = '{1, 3, 1, 3};
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    in_data = {3'd7, 3'd6, 3'd5, 3'd4};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_chan !== 2'(exp_a[i]) || out_data !== 3'(exp_a[i] + 4)) begin
        failures++; $display("FAIL rr_all[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", i, out_valid, out_chan, out_data, exp_a[i], exp_a[i] + 4); end
    end
    do_reset();
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_chan !== 2'(exp_b[i])) begin
        failures++; $display("FAIL rr_sparse[%0d] got=%b/%0d exp=1/%0d", i, out_valid, out_chan, exp_b[i]); end
    end
  endtask

  task automatic test_wrap_three();
    int exp_c [4] = '{0, 1, 2, 0};
    do_reset();
    mode3 = 1'b1; in_valid3 = 3'b111; out_ready3 = 1'b1; in_data3 = {3'd6, 3'd5, 3'd4};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid3 !== 1'b1 || out_chan3 !== 2'(exp_c[i]) || out_data3 !== 3'(exp_c[i] + 4)) begin
        failures++; $display("FAIL wrap3[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", i, out_valid3, out_chan3, out_data3, exp_c[i], exp_c[i] + 4); end
    end
    mode3 = 1'b0; sel3 = 2'd3; #1;
    checks++; if (in_ready3 !== 3'b000) begin failures++; $display("FAIL sel_oob_ready got=%b exp=000", in_ready3); end
    @(posedge clk); #1;
    checks++; if (out_valid3 !== 1'b0) begin failures++; $display("FAIL sel_oob_valid got=%b exp=0", out_valid3); end
    in_valid3 = 3'b000; out_ready3 = 1'b0;
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1; in_data = {3'd7, 3'd6, 3'd3, 3'd1};
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 3'd3) begin
      failures++; $display("FAIL ms_first got=%b/%0d/%0d exp=1/1/3", out_valid, out_chan, out_data); end
    out_ready = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL ms_stall_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 3'd3) begin
      failures++; $display("FAIL ms_held got=%b/%0d/%0d exp=1/1/3", out_valid, out_chan, out_data); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL ms_fixed_ready got=%b exp=0001", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_chan !== 2'd0 || out_data !== 3'd1) begin
      failures++; $display("FAIL ms_fixed_out got=%0d/%0d exp=0/1", out_chan, out_data); end
    mode = 1'b1; #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL ms_resume_ready got=%b exp=0100", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_chan !== 2'd2 || out_data !== 3'd6) begin
      failures++; $display("FAIL ms_resume_out got=%0d/%0d exp=2/6", out_chan, out_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_data = {3'd7, 3'd6, 3'd5, 3'd4};
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_chan !== 2'd1) begin
      failures++; $display("FAIL ar_pre got=%b/%0d exp=1/1", out_valid, out_chan); end
    #2; rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 3'd0 || out_chan !== 2'd0 || in_ready !== 4'b0000) begin
      failures++; $display("FAIL ar_clear got=%b/%0d/%0d/%b exp=0/0/0/0000", out_valid, out_data, out_chan, in_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL ar_resume_ready got=%b exp=0001", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 3'd4) begin
      failures++; $display("FAIL ar_resume got=%b/%0d/%0d exp=1/0/4", out_valid, out_chan, out_data); end
  endtask

  task automatic test_random();
    int         g;
    bit         le;
    logic [C-1:0] exp_rdy;
    do_reset();
    mv = 1'b0; md = '0; mc = 0; mp = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g       = ref_grant(mode, int'(sel), in_valid, mp);
      le      = !mv || out_ready;
      exp_rdy = (g >= 0 && le) ? 4'(1 << g) : 4'b0000;
      checks++; if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy); end
      if (le) begin
        if (g >= 0 && in_valid[g]) begin
          mv = 1'b1; md = in_data[g*W +: W]; mc = g;
          if (mode) mp = (g + 1) % C;
        end else begin
          mv = 1'b0;
        end
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== mv) begin
        failures++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, out_valid, mv); end
      if (mv) begin
        checks++; if (out_data !== md || out_chan !== 2'(mc)) begin
          failures++; $display("FAIL rand_word[%0d] got=%0d/%0d exp=%0d/%0d", i, out_data, out_chan, md, mc); end
      end
    end
  endtask

  initial begin
    in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b0;
    test_reset();
    test_backpressure();
    test_rr_fairness();
    test_wrap_three();
    test_mode_switch();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
